reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Central reset controller between the Chiselwatt PLL and the core/peripheral blocks.
//  Merges the reset sources into one request: PLL lock loss, the board button, a software request and an optional watchdog.
//  Holds every downstream reset asserted for a fixed interval after the request clears.
//  Then releases NUM_STAGES reset outputs in order (stage 0 first, e.g. memory, then core) and records the reset cause.
// PARAMETERS
//  NUM_STAGES        2        number of staged reset outputs (>=1)
//  HOLD_CYCLES       4194303  cycles all resets stay asserted after the last active request (>=1)
//  STAGE_GAP         16       cycles between consecutive stage releases (>=1)
//  DEBOUNCE_CYCLES   65536    consecutive stable cycles before the button state changes (>=1)
//  BUTTON_ACTIVE_LOW 1        1: io_button low = pressed; 0: high = pressed
//  WDT_CYCLES        16777216 watchdog timeout in cycles (used only with WATCHDOG_EN)
// PORTS
//  clock         in   1           PLL output clock; the only clock
//  reset         in   1           synchronous, active-high; forces the ASSERT state
//  io_lock       in   1           PLL lock, asynchronous; passes through a 2-FF synchroniser
//  io_button     in   1           board reset button, asynchronous; 2-FF sync, polarity fix, debounce
//  io_swReset    in   1           single-cycle software reset request from the core
//  io_wdKick     in   1           watchdog reload pulse (ignored without WATCHDOG_EN)
//  io_resetOut   out  NUM_STAGES  active-high reset for each stage, registered
//  io_ready      out  1           1 when all stages are released (RUN state), registered
//  io_cause      out  5           sticky cause: [0] reset, [1] lock loss, [2] button, [3] sw, [4] watchdog
// BEHAVIOUR
//  Request (trig), evaluated each cycle:
//   - lock_sync==0, OR debounced button pressed, OR io_swReset, OR wdt_expire.
//   - Lock and button are level requests; io_swReset and the watchdog are pulses.
//  Reset values: io_resetOut all 1; io_ready 0; io_cause 5'b00001.
//   - State = ASSERT; hold counter = HOLD_CYCLES; button debounced state = released.
//  ASSERT state:
//   - All io_resetOut held at 1.
//   - Cycle with trig: counter reloads to HOLD_CYCLES.
//   - Cycle without trig: counter decrements by 1.
//   - Counter==0 with no trig -> RELEASE, stage index 0, io_resetOut[0] <= 0.
//   - Timing: stage 0 drops HOLD_CYCLES+1 cycles after the last trig cycle.
//  RELEASE state:
//   - Gap counter runs STAGE_GAP cycles, then releases the next stage.
//   - Stage k drops k*STAGE_GAP cycles after stage 0.
//   - On the cycle the last stage drops: state -> RUN and io_ready <= 1 (same edge).
//   - NUM_STAGES==1: go from ASSERT directly to RUN; stage 0 and io_ready change together.
//  RUN state: all io_resetOut=0, io_ready=1.
//  trig in RELEASE or RUN:
//   - Next edge: all io_resetOut <= 1, io_ready <= 0, state -> ASSERT, counter = HOLD_CYCLES.
//   - io_cause is overwritten with the cause bits of that cycle.
//  trig in ASSERT: io_cause |= the cause bits of that cycle (several simultaneous causes are OR-ed).
//  Block reset while in any state: same as the reset values; io_cause = 5'b00001 only.
//  Debounce:
//   - Synced, polarity-corrected button must differ from the debounced state for DEBOUNCE_CYCLES consecutive cycles before the state flips.
//   - Any shorter pulse leaves the state unchanged.
//  Counters: widths are $clog2(param+1); they never wrap, and all decrements saturate at 0.
//  Outputs are glitch-free: every output comes straight from a flop.
// CONFIGURATION
//  CHISELWATT_WATCHDOG_EN defined:
//   - A WDT_CYCLES down-counter runs only in RUN.
//   - It reloads on entry to RUN and on each io_wdKick.
//   - Reaching 0 gives a one-cycle wdt_expire, which sets cause bit [4].
//  Not defined: no watchdog logic; io_wdKick is unused; io_cause[4] is tied to 0.
// TESTING  (NUM_STAGES=3, HOLD=8, GAP=4, DEBOUNCE=4, WDT=32, io_lock=1, button released)
//  1. reset high 2 cycles then low (cycle 0)
//     -> io_resetOut[0] falls at cycle 9, [1] at 13, [2] and io_ready at 17; io_cause=00001.
//  2. In RUN, io_lock low for 1 cycle
//     -> all resets reassert 3 edges later; io_cause=00010.
//     -> stage 0 releases HOLD+1 cycles after the synced lock returns high.
//  3. Button pressed 3 cycles -> no effect.
//     Button pressed 6 cycles -> resets reassert; io_cause=00100; hold restarts when the debounced state releases.
//  4. io_swReset pulse while stage 1 is still in reset (RELEASE)
//     -> all stages reassert, io_cause=01000, full sequence restarts.
//  5. io_swReset on the same cycle the debounced button becomes pressed, in RUN -> io_cause=01100.
//  6. WATCHDOG_EN: no kick for 32 cycles in RUN -> reset, io_cause=10000.
//     Kicks every 20 cycles -> io_ready stays 1 for 1000 cycles.
//     Without WATCHDOG_EN: no reset ever occurs.

Source files
------------

// File: rtl/reset_sequencer.sv
// Central reset controller: merges PLL lock loss, button, software and watchdog requests,
// holds all resets, then releases NUM_STAGES outputs in order. Watchdog: define CHISELWATT_WATCHDOG_EN.
module reset_sequencer #(
  parameter int NUM_STAGES        = 2,
  parameter int HOLD_CYCLES       = 4194303,
  parameter int STAGE_GAP         = 16,
  parameter int DEBOUNCE_CYCLES   = 65536,
  parameter int BUTTON_ACTIVE_LOW = 1,
  parameter int WDT_CYCLES        = 16777216
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_lock,
  input  logic                  io_button,
  input  logic                  io_swReset,
  input  logic                  io_wdKick,
  output logic [NUM_STAGES-1:0] io_resetOut,
  output logic                  io_ready,
  output logic [4:0]            io_cause
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [HW-1:0] HOLD_LOAD    = HW'(HOLD_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD     = GW'(STAGE_GAP - 1);
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  // stage_idx is the most recently released stage; this value means the next release is the last
  localparam logic [SW-1:0] LAST_GAP_IDX = SW'(NUM_STAGES - 2);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [HW-1:0]           hold_cnt;
  logic [GW-1:0]           gap_cnt;
  logic [SW-1:0]           stage_idx;
  logic [1:0]              lock_ff;
  logic [1:0]              button_ff;
  logic                    lock_sync;
  logic                    button_pressed_sync;
  logic                    deb_q;
  logic [DW-1:0]           deb_cnt;
  logic                    wdt_expire;
  logic [4:0]              cause_bits;
  logic                    trig;
  logic [NUM_STAGES-1:0]   reset_out_d;
  logic                    ready_d;
  logic [4:0]              cause_d;

  // Synchronisers carry no reset so they are already filled with live input values when reset drops
  always_ff @(posedge clock) begin
    lock_ff   <= {lock_ff[0], io_lock};
    button_ff <= {button_ff[0], io_button};
  end

  assign lock_sync           = lock_ff[1];
  assign button_pressed_sync = (BUTTON_ACTIVE_LOW != 0) ? ~button_ff[1] : button_ff[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else if (button_pressed_sync == deb_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_q   <= ~deb_q;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

`ifdef CHISELWATT_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LOAD = WW'(WDT_CYCLES);

  logic [WW-1:0] wdt_cnt;

  // Held at the load value outside RUN, which gives a fresh count on every entry to RUN
  always_ff @(posedge clock) begin
    if (reset) begin
      wdt_cnt <= WDT_LOAD;
    end else if (state_q != ST_RUN || io_wdKick) begin
      wdt_cnt <= WDT_LOAD;
    end else if (wdt_cnt != '0) begin
      wdt_cnt <= wdt_cnt - 1'b1;
    end
  end

  assign wdt_expire = (state_q == ST_RUN) && (wdt_cnt == '0);
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic unused_wdkick;
  assign unused_wdkick = io_wdKick;
  assign wdt_expire    = 1'b0;
`endif

  assign cause_bits = {wdt_expire, io_swReset, deb_q, ~lock_sync, 1'b0};
  assign trig       = |cause_bits;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt  <= HOLD_LOAD;
      gap_cnt   <= GAP_LOAD;
      stage_idx <= '0;
    end else begin
      if (trig) begin
        hold_cnt <= HOLD_LOAD;
      end else if (state_q == ST_ASSERT && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end

      if (state_q != ST_RELEASE) begin
        gap_cnt   <= GAP_LOAD;
        stage_idx <= '0;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end else begin
        gap_cnt <= GAP_LOAD;
        if (stage_idx != LAST_GAP_IDX) begin
          stage_idx <= stage_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      io_resetOut <= '1;
      io_ready    <= 1'b0;
      io_cause    <= 5'b00001;
    end else begin
      state_q     <= state_d;
      io_resetOut <= reset_out_d;
      io_ready    <= ready_d;
      io_cause    <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (trig) begin
      state_d = ST_ASSERT;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_cnt == '0) begin
            state_d = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (gap_cnt == '0 && stage_idx == LAST_GAP_IDX) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_ASSERT;
      endcase
    end
  end

  // Next values of the output flops; a trig outside ASSERT starts a fresh cause record
  always_comb begin
    reset_out_d = io_resetOut;
    ready_d     = io_ready;
    cause_d     = io_cause;
    if (trig) begin
      reset_out_d = '1;
      ready_d     = 1'b0;
      cause_d     = (state_q == ST_ASSERT) ? (io_cause | cause_bits) : cause_bits;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          reset_out_d = '1;
          if (hold_cnt == '0) begin
            reset_out_d[0] = 1'b0;
            if (NUM_STAGES == 1) begin
              ready_d = 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (gap_cnt == '0) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (i <= int'(stage_idx) + 1) begin
                reset_out_d[i] = 1'b0;
              end
            end
            if (stage_idx == LAST_GAP_IDX) begin
              ready_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          reset_out_d = '0;
          ready_d     = 1'b1;
        end
        default: begin
          reset_out_d = '1;
          ready_d     = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: release timeline table, request event table, reset/software corner
// cases and the watchdog (behaviour selected by CHISELWATT_WATCHDOG_EN).
module tb_reset_sequencer;

  localparam int NS   = 3;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int DEB  = 4;
  localparam int WDT  = 32;
  localparam int OW   = NS + 6;
  localparam int TL_N = 8;
  localparam int EV_N = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_lock;
  logic          io_button;
  logic          io_swReset;
  logic          io_wdKick;
  logic [NS-1:0] io_resetOut;
  logic          io_ready;
  logic [4:0]    io_cause;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] exp_q[$];
  logic [4:0]    cur_cause;

  typedef struct {
    int            at;
    logic [NS-1:0] rst;
    logic          rdy;
  } tl_t;

  typedef struct {
    int         lock_low;
    int         btn_len;
    int         sw_at;
    int         assert_at;
    int         last_trig;
    logic [4:0] cause;
  } ev_t;

  tl_t   tl[TL_N];
  ev_t   ev[EV_N];
  string ev_name[EV_N];

  reset_sequencer #(
    .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
    .DEBOUNCE_CYCLES(DEB), .BUTTON_ACTIVE_LOW(1), .WDT_CYCLES(WDT)
  ) dut (
    .clock(clock), .reset(reset), .io_lock(io_lock), .io_button(io_button),
    .io_swReset(io_swReset), .io_wdKick(io_wdKick), .io_resetOut(io_resetOut),
    .io_ready(io_ready), .io_cause(io_cause)
  );

  // clock / time limit
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [OW-1:0] pack(logic [NS-1:0] r, logic rdy, logic [4:0] c);
    return {r, rdy, c};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rst=%b rdy=%b cause=%b, expected rst=%b rdy=%b cause=%b",
               name, act[OW-1:6], act[5], act[4:0], exp[OW-1:6], exp[5], exp[4:0]);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_pop_check(string name);
    if (exp_q.size() == 0) begin
      check_int({name, "_queue_empty"}, 0, 1);
    end else begin
      check(name, pack(io_resetOut, io_ready, io_cause), exp_q.pop_front());
    end
  endtask

  task automatic wait_ready(string name, int budget);
    int n = 0;
    while (!io_ready && n < budget) begin
      step();
      n++;
    end
    check_int({name, "_reaches_ready"}, int'(io_ready), 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.push_back(pack('1, 1'b0, 5'b00001));
    step();
    sb_pop_check("reset_values");
    step();
    reset = 1'b0;
    cur_cause = 5'b00001;
  endtask

  // Called just after the edge that saw the last request; walks the release schedule
  task automatic run_timeline(string name, logic [4:0] cause);
    int idx = 0;
    for (int i = 0; i < TL_N; i++) exp_q.push_back(pack(tl[i].rst, tl[i].rdy, cause));
    for (int off = 0; off <= tl[TL_N-1].at; off++) begin
      if (off > 0) step();
      if (idx < TL_N && tl[idx].at == off) begin
        sb_pop_check($sformatf("%s_t%0d", name, off));
        idx++;
      end
    end
    cur_cause = cause;
  endtask

  initial begin
    int horizon;
    int drops;

    tl[0] = '{0,  3'b111, 1'b0};
    tl[1] = '{8,  3'b111, 1'b0};
    tl[2] = '{9,  3'b110, 1'b0};
    tl[3] = '{12, 3'b110, 1'b0};
    tl[4] = '{13, 3'b100, 1'b0};
    tl[5] = '{16, 3'b100, 1'b0};
    tl[6] = '{17, 3'b000, 1'b1};
    tl[7] = '{20, 3'b000, 1'b1};

    ev[0] = '{1, 0, -1, 3,  3,  5'b00010}; ev_name[0] = "lock_blip";
    ev[1] = '{5, 0, -1, 3,  7,  5'b00010}; ev_name[1] = "lock_long";
    ev[2] = '{0, 3, -1, -1, -1, 5'b00000}; ev_name[2] = "btn_short";
    ev[3] = '{0, 6, -1, 7,  12, 5'b00100}; ev_name[3] = "btn_long";
    ev[4] = '{0, 0, 0,  1,  1,  5'b01000}; ev_name[4] = "sw_run";
    ev[5] = '{0, 7, 6,  7,  13, 5'b01100}; ev_name[5] = "sw_with_btn";

    reset      = 1'b1;
    io_lock    = 1'b1;
    io_button  = 1'b1;
    io_swReset = 1'b0;
    io_wdKick  = 1'b1;
    cur_cause  = 5'b00001;

    apply_reset();
    run_timeline("por", 5'b00001);

    for (int e = 0; e < EV_N; e++) begin
      wait_ready(ev_name[e], 100);
      drops = 0;
      horizon = (ev[e].assert_at < 0) ? 12 : ev[e].last_trig;
      if (ev[e].assert_at >= 0) exp_q.push_back(pack('1, 1'b0, ev[e].cause));
      else exp_q.push_back(pack('0, 1'b1, cur_cause));
      for (int off = 0; off <= horizon; off++) begin
        if (off > 0) step();
        if (!io_ready && ev[e].assert_at < 0) drops++;
        if (ev[e].assert_at >= 0 && off == ev[e].assert_at - 1)
          check({ev_name[e], "_before"}, pack(io_resetOut, io_ready, io_cause),
                pack('0, 1'b1, cur_cause));
        if (off == ev[e].assert_at) sb_pop_check({ev_name[e], "_assert"});
        io_lock    = (off < ev[e].lock_low) ? 1'b0 : 1'b1;
        io_button  = (off < ev[e].btn_len) ? 1'b0 : 1'b1;
        io_swReset = (off == ev[e].sw_at);
      end
      if (ev[e].assert_at >= 0) begin
        run_timeline(ev_name[e], ev[e].cause);
      end else begin
        sb_pop_check({ev_name[e], "_no_effect"});
        check_int({ev_name[e], "_ready_drops"}, drops, 0);
      end
    end

    // block reset from RUN clears the cause, then a software request mid-release restarts it all
    apply_reset();
    for (int off = 1; off <= 11; off++) begin
      step();
      if (off == 9) check("rst_release_stage0", pack(io_resetOut, io_ready, io_cause),
                          pack(3'b110, 1'b0, 5'b00001));
    end
    io_swReset = 1'b1;
    exp_q.push_back(pack('1, 1'b0, 5'b01000));
    step();
    io_swReset = 1'b0;
    sb_pop_check("sw_in_release");
    run_timeline("sw_restart", 5'b01000);

`ifdef CHISELWATT_WATCHDOG_EN
    io_wdKick = 1'b0;
    begin
      int n = 0;
      while (io_ready && n < WDT + 20) begin
        step();
        n++;
      end
    end
    check("wdt_expire", pack(io_resetOut, io_ready, io_cause), pack('1, 1'b0, 5'b10000));
    io_wdKick = 1'b1;
    wait_ready("wdt_recover", 100);
    drops = 0;
    for (int c = 0; c < 1000; c++) begin
      io_wdKick = (c % 20 == 0);
      step();
      if (!io_ready) drops++;
    end
    check_int("wdt_kicked_ready_drops", drops, 0);
`else
    io_wdKick = 1'b0;
    drops = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (!io_ready) drops++;
    end
    check_int("no_wdt_ready_drops", drops, 0);
    check("no_wdt_final", pack(io_resetOut, io_ready, io_cause), pack('0, 1'b1, 5'b01000));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
